// File: rtl/counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_seq
// Brief    : Command sequencer driving an external up/down counter
//            (load strobe, direction, step enable). Optional 2-entry command
//            FIFO enabled by defining CMD_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module counter_cmd_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_arg,
    input  logic         hold,
    output logic         ld_cnt_,
    output logic         updn_cnt,
    output logic         count_enb,
    output logic [W-1:0] data_in,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [1:0] c_op_nop  = 2'b00;
    localparam logic [1:0] c_op_load = 2'b01;
    localparam logic [1:0] c_op_up   = 2'b10;
    localparam logic [1:0] c_op_down = 2'b11;

    state_t         state_q, state_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           ld_cnt_q, ld_cnt_d;
    logic           updn_q, updn_d;
    logic           enb_q, enb_d;
    logic [W-1:0]   data_q, data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           w_have_cmd;
    logic [1:0]     w_head_op;
    logic [W-1:0]   w_head_arg;

`ifdef CMD_FIFO_EN
    logic [1:0]     fifo_op_q  [2];
    logic [1:0]     fifo_op_d  [2];
    logic [W-1:0]   fifo_arg_q [2];
    logic [W-1:0]   fifo_arg_d [2];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           w_push, w_pop, w_full, w_empty;

    assign w_full     = (cnt_q == 2'd2);
    assign w_empty    = (cnt_q == 2'd0);
    assign cmd_ready  = !w_full && !rst;
    assign w_push     = cmd_valid && cmd_ready;
    // Commands always pass through the FIFO, so a push never bypasses IDLE.
    assign w_pop      = (state_q == S_IDLE) && !w_empty;
    assign w_have_cmd = !w_empty;
    assign w_head_op  = fifo_op_q[rd_ptr_q];
    assign w_head_arg = fifo_arg_q[rd_ptr_q];

    always_comb begin
        fifo_op_d  = fifo_op_q;
        fifo_arg_d = fifo_arg_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (w_push) begin
            fifo_op_d[wr_ptr_q]  = cmd_op;
            fifo_arg_d[wr_ptr_q] = cmd_arg;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_op_q[0]  <= '0;
            fifo_op_q[1]  <= '0;
            fifo_arg_q[0] <= '0;
            fifo_arg_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
        end else begin
            fifo_op_q  <= fifo_op_d;
            fifo_arg_q <= fifo_arg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end
`else
    assign cmd_ready  = (state_q == S_IDLE) && !rst;
    assign w_have_cmd = cmd_valid && cmd_ready;
    assign w_head_op  = cmd_op;
    assign w_head_arg = cmd_arg;
`endif

    // Outputs are computed for the next cycle, so every port comes from a flop.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        ld_cnt_d = 1'b1;
        updn_d   = updn_q;
        enb_d    = 1'b0;
        data_d   = data_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_have_cmd) begin
                    case (w_head_op)
                        c_op_load: begin
                            state_d  = S_LOAD;
                            ld_cnt_d = 1'b0;
                            data_d   = w_head_arg;
                        end
                        c_op_up, c_op_down: begin
                            if (w_head_arg != '0) begin
                                state_d = S_COUNT;
                                updn_d  = (w_head_op == c_op_up);
                                enb_d   = 1'b1;
                                rem_d   = w_head_arg - W'(1);
                            end else begin
                                state_d = S_FIN;
                                done_d  = 1'b1;
                            end
                        end
                        c_op_nop: begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                state_d = S_FIN;
                done_d  = 1'b1;
            end
            S_COUNT: begin
                // rem_q counts steps still to issue after the current one.
                if (rem_q == '0) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else if (!hold) begin
                    enb_d = 1'b1;
                    rem_d = rem_q - W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            ld_cnt_q <= 1'b1;
            updn_q   <= 1'b0;
            enb_q    <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            ld_cnt_q <= ld_cnt_d;
            updn_q   <= updn_d;
            enb_q    <= enb_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ld_cnt_   = ld_cnt_q;
    assign updn_cnt  = updn_q;
    assign count_enb = enb_q;
    assign data_in   = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_cmd_seq
// Brief    : Scoreboard bench for counter_cmd_seq; directed commands push
//            expected load/step/done events, a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_cmd_seq;

    localparam int W = 8;
    localparam int K_LD = 0;
    localparam int K_STEP = 1;
    localparam int K_DONE = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic         hold;
    logic         ld_cnt_;
    logic         updn_cnt;
    logic         count_enb;
    logic [W-1:0] data_in;
    logic         busy;
    logic         done;

    counter_cmd_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .hold      (hold),
        .ld_cnt_   (ld_cnt_),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int at;
    } evt_t;

    evt_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_evt(input int k, input int v, input int at);
        exp_q.push_back('{kind: k, val: v, at: at});
    endtask

    task automatic take(input int k, input int v);
        evt_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_evt_kind", k, -1);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", k, e.kind);
            check("evt_val", v, e.val);
            if (e.at >= 0) check("evt_cycle", cyc, e.at);
        end
    endtask

    // Monitor: every load strobe, step and done pulse must match the queue head.
    always @(negedge clk) begin
        if (ld_cnt_ !== 1'b1) take(K_LD, int'(data_in));
        if (count_enb !== 1'b0) take(K_STEP, int'(updn_cnt));
        if (done !== 1'b0) take(K_DONE, 0);
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] arg, output int t);
        int n;
        n = 0;
        @(negedge clk);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", int'(n < 200), 1);
        t = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("idle_bound", int'(n < 600), 1);
        @(negedge clk);
    endtask

    task automatic at_cycle(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_arg   = 8'h77;
        hold      = 1'b0;

        // Reset with a command offered: nothing accepted, outputs at reset values.
        repeat (2) begin
            @(negedge clk);
            check("rst_cmd_ready", int'(cmd_ready), 0);
            check("rst_ld_cnt_", int'(ld_cnt_), 1);
            check("rst_count_enb", int'(count_enb), 0);
            check("rst_data_in", int'(data_in), 0);
            check("rst_done", int'(done), 0);
            check("rst_busy", int'(busy), 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;

        // LOAD A5: one load cycle, then done.
        issue(2'b01, 8'hA5, t);
        expect_evt(K_LD, 8'hA5, t + 1);
        expect_evt(K_DONE, 0, t + 2);
        wait_idle();

        // UP 3: steps t+1..t+3, done t+4, ready again at t+5.
        issue(2'b10, 8'd3, t);
        for (int i = 1; i <= 3; i++) expect_evt(K_STEP, 1, t + i);
        expect_evt(K_DONE, 0, t + 4);
        at_cycle(t + 4);
        check("ready_in_fin", int'(cmd_ready), 0);
        at_cycle(t + 5);
        check("ready_after_fin", int'(cmd_ready), 1);
        check("data_in_held", int'(data_in), 8'hA5);
        wait_idle();

        // UP 4 with hold during two cycles after the first step.
        issue(2'b10, 8'd4, t);
        hold = 1'b1;
        expect_evt(K_STEP, 1, t + 1);
        expect_evt(K_STEP, 1, t + 4);
        expect_evt(K_STEP, 1, t + 5);
        expect_evt(K_STEP, 1, t + 6);
        expect_evt(K_DONE, 0, t + 7);
        at_cycle(t + 2);
        check("hold1_enb", int'(count_enb), 0);
        check("hold1_updn", int'(updn_cnt), 1);
        @(posedge clk);
        #1;
        hold = 1'b0;
        at_cycle(t + 3);
        check("hold2_enb", int'(count_enb), 0);
        check("hold2_updn", int'(updn_cnt), 1);
        check("hold2_busy", int'(busy), 1);
        wait_idle();

        // DOWN 3, DOWN 0, NOP.
        issue(2'b11, 8'd3, t);
        for (int i = 1; i <= 3; i++) expect_evt(K_STEP, 0, t + i);
        expect_evt(K_DONE, 0, t + 4);
        wait_idle();
        issue(2'b11, 8'd0, t);
        expect_evt(K_DONE, 0, t + 1);
        wait_idle();
        issue(2'b00, 8'd9, t);
        expect_evt(K_DONE, 0, t + 1);
        wait_idle();
        check("data_in_after_nop", int'(data_in), 8'hA5);

        // Maximum argument: 255 steps.
        issue(2'b10, 8'hFF, t);
        for (int i = 1; i <= 255; i++) expect_evt(K_STEP, 1, t + i);
        expect_evt(K_DONE, 0, t + 256);
        wait_idle();

        // Reset during the 2nd step of UP 5 aborts with no done.
        issue(2'b10, 8'd5, t);
        expect_evt(K_STEP, 1, t + 1);
        expect_evt(K_STEP, 1, t + 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_in_rst", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_enb", int'(count_enb), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_ld", int'(ld_cnt_), 1);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_data_in", int'(data_in), 0);
        repeat (4) @(negedge clk);

`ifdef CMD_FIFO_EN
        // Back-to-back commands through the FIFO execute in order.
        expect_evt(K_LD, 10, -1);
        expect_evt(K_DONE, 0, -1);
        for (int i = 0; i < 3; i++) expect_evt(K_STEP, 1, -1);
        expect_evt(K_DONE, 0, -1);
        for (int i = 0; i < 2; i++) expect_evt(K_STEP, 0, -1);
        expect_evt(K_DONE, 0, -1);
        issue(2'b01, 8'd10, t);
        issue(2'b10, 8'd3, t);
        issue(2'b11, 8'd2, t);
        wait_idle();
`endif

        wait_idle();
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
